// File: rtl/spi_ram_master_ctrl.sv
// spi_ram_master_ctrl: host-side sequencer for the SPI slave + single-port RAM.
// Each accepted byte command becomes two 10-bit frames (address, then data),
// shifted MSB first on MOSI, one bit per clk. Read-data frames are followed by
// a turnaround and an 8-bit MISO capture.
// Optional build macro SPI_RAM_ADDR_CACHE_EN: remember the last write and read
// address frames sent and skip the address frame on a matching command.
module spi_ram_master_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int IDLE_GAP   = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              done,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, so the command is
  // captured once and cmd_ready drops the following cycle. done is a one-cycle
  // pulse with no backpressure.

  localparam int FRAME_W = ADDR_W + 2;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_TURN, S_CAPTURE, S_GAP
  } state_t;

  state_t              state;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic                data_phase;   // 0 = address frame in flight, 1 = data frame
  logic [FRAME_W-1:0]  shreg;
  logic [6:0]          rx;
  logic [CNT_W-1:0]    cnt;
  logic                cache_hit;
  logic                load_data;
  logic [FRAME_W-1:0]  next_frame;
  logic                addr_frame_end;

  // Last cycle of an address frame: the point where the address is known sent.
  assign addr_frame_end = (state == S_SHIFT) && (cnt == CNT_W'(FRAME_W-1)) && !data_phase;

`ifdef SPI_RAM_ADDR_CACHE_EN
  logic              wc_valid, rc_valid;
  logic [ADDR_W-1:0] wc_addr, rc_addr;

  // A command hits only against the cached address of its own type.
  always_comb begin
    cache_hit = 1'b0;
    if (wr_q) cache_hit = wc_valid && (wc_addr == addr_q);
    else      cache_hit = rc_valid && (rc_addr == addr_q);
  end

  // Record each address frame once it has fully gone out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_valid <= 1'b0;
      rc_valid <= 1'b0;
      wc_addr  <= '0;
      rc_addr  <= '0;
    end else if (addr_frame_end) begin
      if (wr_q) begin
        wc_valid <= 1'b1;
        wc_addr  <= addr_q;
      end else begin
        rc_valid <= 1'b1;
        rc_addr  <= addr_q;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  assign load_data = data_phase | cache_hit;

  // Frame built in LOAD: opcode in the top two bits, payload below.
  always_comb begin
    next_frame = '0;
    if (!load_data)  next_frame = {(wr_q ? 2'b00 : 2'b10), addr_q};
    else if (wr_q)   next_frame = {2'b01, ADDR_W'(wdata_q)};
    else             next_frame = {2'b11, {ADDR_W{1'b0}}};
  end

  // Sequencer FSM; every SPI and host output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rsp_rdata  <= 8'h00;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      data_phase <= 1'b0;
      shreg      <= '0;
      rx         <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            wr_q       <= cmd_write;
            addr_q     <= cmd_addr;
            wdata_q    <= cmd_wdata;
            data_phase <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Bit 9 goes out together with SS_n falling.
          MOSI       <= next_frame[FRAME_W-1];
          shreg      <= {next_frame[FRAME_W-2:0], 1'b0};
          SS_n       <= 1'b0;
          cnt        <= '0;
          data_phase <= load_data;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(FRAME_W-1)) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (data_phase && !wr_q) begin
              state <= S_TURN;
            end else begin
              SS_n  <= 1'b1;
              done  <= data_phase;
              state <= S_GAP;
            end
          end else begin
            MOSI  <= shreg[FRAME_W-1];
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (cnt == CNT_W'(RD_LATENCY-1)) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          rx <= {rx[5:0], MISO};
          if (cnt == CNT_W'(7)) begin
            cnt       <= '0;
            SS_n      <= 1'b1;
            done      <= 1'b1;
            rsp_rdata <= {rx, MISO};
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(IDLE_GAP-1)) begin
            cnt <= '0;
            if (data_phase) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              data_phase <= 1'b1;
              state      <= S_LOAD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Bench for spi_ram_master_ctrl: two instances (default timing and
// IDLE_GAP=3 / RD_LATENCY=2). A per-command timeline of SS_n/MOSI/done is
// derived from the frame rules and compared every cycle; a RAM array acts as
// the slave's memory and supplies MISO bytes.
module tb_spi_ram_master_ctrl;

  localparam int GAP0 = 1, LAT0 = 1, GAP1 = 3, LAT1 = 2;
  localparam int K_IDLE = 0, K_BIT = 1, K_TURN = 2, K_CAP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_write [2];
  logic [7:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  logic       done      [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic       ss_n      [2];
  logic       mosi      [2];
  logic       miso      [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] ram [2][256];
  logic [7:0] last_rdata [2];
`ifdef SPI_RAM_ADDR_CACHE_EN
  logic       c_wv [2];
  logic       c_rv [2];
  logic [7:0] c_wa [2];
  logic [7:0] c_ra [2];
`endif

  // Expected per-cycle timeline of the command in flight (index 0 = cycle 1)
  logic t_ss [$];
  logic t_mosi [$];
  logic t_done [$];
  logic t_miso [$];
  int   t_kind [$];

  always #5 clk = ~clk;

  spi_ram_master_ctrl #(.ADDR_W(8), .IDLE_GAP(GAP0), .RD_LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .done(done[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_ram_master_ctrl #(.ADDR_W(8), .IDLE_GAP(GAP1), .RD_LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .done(done[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic add_cycle(input logic s, input logic m, input int kind, input logic mi, input logic d);
    t_ss.push_back(s);
    t_mosi.push_back(m);
    t_kind.push_back(kind);
    t_miso.push_back(mi);
    t_done.push_back(d);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      last_rdata[u] = 8'h00;
`ifdef SPI_RAM_ADDR_CACHE_EN
      c_wv[u] = 1'b0;
      c_rv[u] = 1'b0;
      c_wa[u] = 8'h00;
      c_ra[u] = 8'h00;
`endif
    end
  endtask

  // Issue one command at the current negedge (instance must be idle) and
  // follow it cycle by cycle until cmd_ready is expected back.
  task automatic run_cmd(input int u, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic keep_valid,
                         output int done_at, output int nfr,
                         output logic [9:0] f_first, output logic [9:0] f_last);
    logic [9:0] fr [$];
    logic [9:0] obs_fr [$];
    logic [9:0] acc;
    logic       skip;
    logic [7:0] rbyte;
    logic [7:0] cur_rsp;
    int         nb, gap, lat, exp_done_at, n;
    gap  = (u == 0) ? GAP0 : GAP1;
    lat  = (u == 0) ? LAT0 : LAT1;
    skip = 1'b0;
`ifdef SPI_RAM_ADDR_CACHE_EN
    skip = wr ? (c_wv[u] && c_wa[u] == addr) : (c_rv[u] && c_ra[u] == addr);
`endif
    if (!skip) fr.push_back(wr ? {2'b00, addr} : {2'b10, addr});
    fr.push_back(wr ? {2'b01, wdata} : 10'h300);
    rbyte = ram[u][addr];
    t_ss.delete(); t_mosi.delete(); t_kind.delete(); t_miso.delete(); t_done.delete();
    exp_done_at = -1;
    foreach (fr[i]) begin
      add_cycle(1'b1, 1'b0, K_IDLE, 1'b0, 1'b0);
      for (int b = 9; b >= 0; b--) add_cycle(1'b0, fr[i][b], K_BIT, 1'b0, 1'b0);
      if (i == fr.size() - 1 && !wr) begin
        for (int j = 0; j < lat; j++) add_cycle(1'b0, 1'b0, K_TURN, 1'b0, 1'b0);
        for (int j = 7; j >= 0; j--) add_cycle(1'b0, 1'b0, K_CAP, rbyte[j], 1'b0);
      end
      for (int j = 0; j < gap; j++) begin
        if (j == 0 && i == fr.size() - 1) begin
          exp_done_at = t_ss.size() + 1;
          add_cycle(1'b1, 1'b0, K_IDLE, 1'b0, 1'b1);
        end else begin
          add_cycle(1'b1, 1'b0, K_IDLE, 1'b0, 1'b0);
        end
      end
    end
    add_cycle(1'b1, 1'b0, K_IDLE, 1'b0, 1'b0);

    cmd_write[u] = wr;
    cmd_addr[u]  = addr;
    cmd_wdata[u] = wdata;
    cmd_valid[u] = 1'b1;
    chk($sformatf("u%0d accept_ready", u), 32'(cmd_ready[u]), 32'd1);
    @(posedge clk);
    n       = t_ss.size();
    cur_rsp = last_rdata[u];
    done_at = -1;
    nb      = 0;
    acc     = 10'h000;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep_valid) begin
          cmd_write[u] = 1'($urandom_range(0, 1));
          cmd_addr[u]  = 8'($urandom());
          cmd_wdata[u] = 8'($urandom());
        end else begin
          cmd_valid[u] = 1'b0;
        end
      end
      if (t_done[k] && !wr) cur_rsp = rbyte;
      chk($sformatf("u%0d c%0d ss_n", u, k + 1), 32'(ss_n[u]), 32'(t_ss[k]));
      chk($sformatf("u%0d c%0d mosi", u, k + 1), 32'(mosi[u]), 32'(t_mosi[k]));
      chk($sformatf("u%0d c%0d done", u, k + 1), 32'(done[u]), 32'(t_done[k]));
      chk($sformatf("u%0d c%0d cmd_ready", u, k + 1), 32'(cmd_ready[u]), 32'(k == n - 1));
      chk($sformatf("u%0d c%0d busy", u, k + 1), 32'(busy[u]), 32'(k != n - 1));
      chk($sformatf("u%0d c%0d rsp_rdata", u, k + 1), 32'(rsp_rdata[u]), 32'(cur_rsp));
      if (done[u] === 1'b1 && done_at < 0) done_at = k + 1;
      if (t_kind[k] == K_BIT) begin
        acc = {acc[8:0], mosi[u]};
        nb++;
        if (nb % 10 == 0) obs_fr.push_back(acc);
      end
      miso[u] = (t_kind[k] == K_CAP) ? t_miso[k] : 1'($urandom_range(0, 1));
    end
    chk($sformatf("u%0d done_cycle", u), 32'(done_at), 32'(exp_done_at));
    chk($sformatf("u%0d frame_count", u), 32'(obs_fr.size()), 32'(fr.size()));
    foreach (fr[i]) if (i < obs_fr.size())
      chk($sformatf("u%0d frame%0d", u, i), 32'(obs_fr[i]), 32'(fr[i]));
    nfr     = obs_fr.size();
    f_first = (obs_fr.size() > 0) ? obs_fr[0] : 10'h000;
    f_last  = (obs_fr.size() > 0) ? obs_fr[obs_fr.size() - 1] : 10'h000;

    if (wr) ram[u][addr] = wdata;
    else    last_rdata[u] = rbyte;
`ifdef SPI_RAM_ADDR_CACHE_EN
    if (!skip) begin
      if (wr) begin c_wv[u] = 1'b1; c_wa[u] = addr; end
      else    begin c_rv[u] = 1'b1; c_ra[u] = addr; end
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         done_at, nfr;
    logic [9:0] f0, f1;
    logic       wr;
    logic [7:0] a, d;

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_write[u] = 1'b0; cmd_addr[u] = 8'h00;
      cmd_wdata[u] = 8'h00; miso[u] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      ram[0][i] = 8'($urandom());
      ram[1][i] = 8'($urandom());
    end
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d rst ss_n", u), 32'(ss_n[u]), 32'd1);
      chk($sformatf("u%0d rst mosi", u), 32'(mosi[u]), 32'd0);
      chk($sformatf("u%0d rst cmd_ready", u), 32'(cmd_ready[u]), 32'd1);
      chk($sformatf("u%0d rst done", u), 32'(done[u]), 32'd0);
      chk($sformatf("u%0d rst busy", u), 32'(busy[u]), 32'd0);
      chk($sformatf("u%0d rst rsp_rdata", u), 32'(rsp_rdata[u]), 32'h00);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed write 0x12 <= 0xAB
    run_cmd(0, 1'b1, 8'h12, 8'hAB, 1'b0, done_at, nfr, f0, f1);
    chk("wr12 done_cycle", 32'(done_at), 32'd24);
    chk("wr12 addr_frame", 32'(f0), 32'h012);
    chk("wr12 data_frame", 32'(f1), 32'h1AB);
    chk("wr12 rsp_unchanged", 32'(rsp_rdata[0]), 32'h00);

    // Directed read 0x12
    run_cmd(0, 1'b0, 8'h12, 8'h00, 1'b0, done_at, nfr, f0, f1);
    chk("rd12 done_cycle", 32'(done_at), 32'd33);
    chk("rd12 addr_frame", 32'(f0), 32'h212);
    chk("rd12 data_frame", 32'(f1), 32'h300);
    chk("rd12 rdata", 32'(rsp_rdata[0]), 32'hAB);

    // Back-to-back with cmd_valid held high
    run_cmd(0, 1'b1, 8'h01, 8'h5A, 1'b1, done_at, nfr, f0, f1);
    run_cmd(0, 1'b1, 8'h02, 8'hC3, 1'b1, done_at, nfr, f0, f1);
    run_cmd(0, 1'b0, 8'h01, 8'h00, 1'b1, done_at, nfr, f0, f1);
    chk("b2b rd01 rdata", 32'(rsp_rdata[0]), 32'h5A);
    chk("b2b rd01 done_cycle", 32'(done_at), 32'd33);
    run_cmd(0, 1'b0, 8'h02, 8'h00, 1'b0, done_at, nfr, f0, f1);
    chk("b2b rd02 rdata", 32'(rsp_rdata[0]), 32'hC3);

    // Reset in the middle of a shifting frame
    cmd_write[0] = 1'b1; cmd_addr[0] = 8'h77; cmd_wdata[0] = 8'h33; cmd_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst pre ss_n", 32'(ss_n[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst ss_n", 32'(ss_n[0]), 32'd1);
    chk("midrst mosi", 32'(mosi[0]), 32'd0);
    chk("midrst cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("midrst busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst hold%0d done", i), 32'(done[0]), 32'd0);
      chk($sformatf("midrst hold%0d ss_n", i), 32'(ss_n[0]), 32'd1);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("postrst cmd_ready", 32'(cmd_ready[0]), 32'd1);
    chk("postrst done", 32'(done[0]), 32'd0);
    chk("postrst rsp_rdata", 32'(rsp_rdata[0]), 32'h00);

    // Two reads of 0x40: second skips the address frame only with the cache
    run_cmd(0, 1'b0, 8'h40, 8'h00, 1'b0, done_at, nfr, f0, f1);
    chk("rd40a done_cycle", 32'(done_at), 32'd33);
    chk("rd40a frames", 32'(nfr), 32'd2);
    run_cmd(0, 1'b0, 8'h40, 8'h00, 1'b0, done_at, nfr, f0, f1);
`ifdef SPI_RAM_ADDR_CACHE_EN
    chk("rd40b done_cycle", 32'(done_at), 32'd21);
    chk("rd40b frames", 32'(nfr), 32'd1);
`else
    chk("rd40b done_cycle", 32'(done_at), 32'd33);
    chk("rd40b frames", 32'(nfr), 32'd2);
`endif
    chk("rd40b last_frame", 32'(f1), 32'h300);

    // Instance with IDLE_GAP=3, RD_LATENCY=2
    run_cmd(1, 1'b1, 8'h21, 8'h96, 1'b0, done_at, nfr, f0, f1);
    chk("u1 wr21 done_cycle", 32'(done_at), 32'd26);
    run_cmd(1, 1'b0, 8'h21, 8'h00, 1'b0, done_at, nfr, f0, f1);
    chk("u1 rd21 done_cycle", 32'(done_at), 32'd36);
    chk("u1 rd21 rdata", 32'(rsp_rdata[1]), 32'h96);

    // Randomized commands over a small address set so the cache sees hits
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 12; i++) begin
        wr = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 7));
        d  = 8'($urandom());
        run_cmd(u, wr, a, d, (i != 11) ? 1'($urandom_range(0, 1)) : 1'b0,
                done_at, nfr, f0, f1);
      end
      cmd_valid[u] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
